// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: opcode field layout, the NOP opcode
// and the fetch FSM state encoding.
package instruction_fetch_pkg;

    localparam int OPCODE_W   = 4;
    localparam int OPCODE_MSB = 27;
    localparam int OPCODE_LSB = 24;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, pipeline control from execute and the
// instruction register handed to decode.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28
);
    logic [ADDR_WIDTH-1:0]  oAddress;
    logic [INSTR_WIDTH-1:0] iInstruction;
    logic                   iStall;
    logic                   iBranchTaken;
    logic [ADDR_WIDTH-1:0]  iBranchTarget;
    logic [INSTR_WIDTH-1:0] oInstruction;
    logic [ADDR_WIDTH-1:0]  oPC;
    logic                   oValid;

    modport master (
        output oAddress,
        input  iInstruction,
        input  iStall,
        input  iBranchTaken,
        input  iBranchTarget,
        output oInstruction,
        output oPC,
        output oValid
    );

    modport slave (
        input  oAddress,
        output iInstruction,
        output iStall,
        output iBranchTaken,
        output iBranchTarget,
        input  oInstruction,
        input  oPC,
        input  oValid
    );
endinterface

// File: rtl/instruction_fetch.sv
// Program counter and instruction register in front of the instruction ROM:
// sequential fetch, stall hold and taken-branch redirect with one flush bubble.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = {ADDR_WIDTH{1'b0}}
) (
    input  logic                Clock,
    input  logic                Reset,
    instruction_fetch_if.master bus
);

    localparam logic [INSTR_WIDTH-1:0] NOP_WORD =
        {OP_NOP, {(INSTR_WIDTH-OPCODE_W){1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_e           state_r, state_s;
    logic [ADDR_WIDTH-1:0]  pc_r, pc_s;
    logic [INSTR_WIDTH-1:0] ir_r, ir_s;
    logic [ADDR_WIDTH-1:0]  ir_pc_r, ir_pc_s;
    logic                   valid_r, valid_s;
    logic                   redirect_s;

    // A branch can only come from a real instruction, so bubbles never redirect.
    assign redirect_s = bus.iBranchTaken & valid_r;

    // Next-state selection: redirect beats stall beats sequential fetch.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        ir_s    = ir_r;
        ir_pc_s = ir_pc_r;
        valid_s = valid_r;
        if (redirect_s) begin
            pc_s    = bus.iBranchTarget;
            ir_s    = NOP_WORD;
            valid_s = 1'b0;
            state_s = FLUSH;
        end else if (bus.iStall) begin
            state_s = state_r;
        end else begin
            case (state_r)
                FETCH, FLUSH: begin
                    ir_s    = bus.iInstruction;
                    ir_pc_s = pc_r;
                    valid_s = 1'b1;
                    pc_s    = pc_r + PC_ONE;
                    state_s = FETCH;
                end
                default: begin
                    state_s = FETCH;
                end
            endcase
        end
    end

    // Pipeline state registers with asynchronous reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            ir_r    <= NOP_WORD;
            ir_pc_r <= {ADDR_WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            ir_r    <= ir_s;
            ir_pc_r <= ir_pc_s;
            valid_r <= valid_s;
        end
    end

    assign bus.oAddress     = pc_r;
    assign bus.oInstruction = ir_r;
    assign bus.oPC          = ir_pc_r;
    assign bus.oValid       = valid_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a combinational ROM model whose
// word for address A is {4'h5, 8'h3C, A}.
module tb_instruction_fetch;

    logic Clock;
    logic Reset;
    int   checks;
    int   failures;

    localparam logic [27:0] NOP = 28'h0000000;

    instruction_fetch_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(28)) bus ();

    instruction_fetch #(.ADDR_WIDTH(16), .INSTR_WIDTH(28), .RESET_PC(16'h0000)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    function automatic logic [27:0] rom_word(input logic [15:0] a);
        return {4'h5, 8'h3C, a};
    endfunction

    assign bus.iInstruction = rom_word(bus.oAddress);

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] addr, input logic [27:0] instr,
                             input logic [15:0] pc, input logic valid);
        check_val({tag, ".addr"},  {16'h0, bus.oAddress}, {16'h0, addr});
        check_val({tag, ".instr"}, {4'h0, bus.oInstruction}, {4'h0, instr});
        check_val({tag, ".pc"},    {16'h0, bus.oPC}, {16'h0, pc});
        check_val({tag, ".valid"}, {31'h0, bus.oValid}, {31'h0, valid});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        bus.iStall        = 1'b0;
        bus.iBranchTaken  = 1'b0;
        bus.iBranchTarget = 16'h0000;

        #2;
        check_all("reset", 16'h0000, NOP, 16'h0000, 1'b0);
        step();
        step();
        Reset = 1'b0;
        check_all("post_reset", 16'h0000, NOP, 16'h0000, 1'b0);

        // Free-running sequential fetch, one instruction per cycle.
        for (int k = 1; k <= 5; k++) begin
            step();
            check_all($sformatf("seq%0d", k), 16'(k), rom_word(16'(k - 1)), 16'(k - 1), 1'b1);
        end

        // Stall for three cycles at PC=5.
        bus.iStall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_all($sformatf("stall%0d", k), 16'h0005, rom_word(16'h0004), 16'h0004, 1'b1);
        end
        bus.iStall = 1'b0;
        step();
        check_all("stall_rel", 16'h0006, rom_word(16'h0005), 16'h0005, 1'b1);

        // Advance until oPC=12.
        for (int k = 0; k < 7; k++) step();
        check_all("at12", 16'h000D, rom_word(16'h000C), 16'h000C, 1'b1);

        // Taken branch to 7: one bubble, then the target.
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = 16'h0007;
        step();
        bus.iBranchTaken  = 1'b0;
        check_val("br7.addr",  {16'h0, bus.oAddress}, 32'h00000007);
        check_val("br7.valid", {31'h0, bus.oValid}, 32'h00000000);
        check_val("br7.instr", {4'h0, bus.oInstruction}, {4'h0, NOP});
        step();
        check_all("br7_tgt", 16'h0008, rom_word(16'h0007), 16'h0007, 1'b1);

        // Branch asserted during the bubble is ignored.
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = 16'h0014;
        step();
        check_val("br20.addr",  {16'h0, bus.oAddress}, 32'h00000014);
        check_val("br20.valid", {31'h0, bus.oValid}, 32'h00000000);
        bus.iBranchTarget = 16'h0003;
        step();
        bus.iBranchTaken  = 1'b0;
        check_all("bubble_ign", 16'h0015, rom_word(16'h0014), 16'h0014, 1'b1);

        // Redirect wins over a simultaneous stall.
        bus.iBranchTaken  = 1'b1;
        bus.iStall        = 1'b1;
        bus.iBranchTarget = 16'h000E;
        step();
        bus.iBranchTaken  = 1'b0;
        bus.iStall        = 1'b0;
        check_val("brst.addr",  {16'h0, bus.oAddress}, 32'h0000000E);
        check_val("brst.valid", {31'h0, bus.oValid}, 32'h00000000);
        step();
        check_all("brst_tgt", 16'h000F, rom_word(16'h000E), 16'h000E, 1'b1);

        // PC wrap from 0xFFFF to 0x0000.
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = 16'hFFFF;
        step();
        bus.iBranchTaken  = 1'b0;
        check_val("wrap.addr", {16'h0, bus.oAddress}, 32'h0000FFFF);
        step();
        check_all("wrap", 16'h0000, rom_word(16'hFFFF), 16'hFFFF, 1'b1);

        // Advance to PC=9, stall, then assert reset between edges.
        for (int k = 0; k < 9; k++) step();
        bus.iStall = 1'b1;
        step();
        check_all("pre_rst", 16'h0009, rom_word(16'h0008), 16'h0008, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check_all("async_rst", 16'h0000, NOP, 16'h0000, 1'b0);
        step();
        Reset      = 1'b0;
        bus.iStall = 1'b0;
        check_all("rst_rel", 16'h0000, NOP, 16'h0000, 1'b0);
        step();
        check_all("rst_fetch", 16'h0001, rom_word(16'h0000), 16'h0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and fetch stage that sits directly upstream of the instruction ROM. It drives the ROM address, captures the combinational 28-bit instruction into an instruction register for decode/execute, and handles sequential increment, stall hold and branch/jump redirection with a one-cycle flush bubble.

## Interface

Parameters:
- ADDR_WIDTH, 16, width of program address / PC
- INSTR_WIDTH, 28, width of instruction word ([27:24] opcode, [23:0] operands)
- RESET_PC, 0, PC value loaded on reset

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- oAddress  out  ADDR_WIDTH  address to ROM iAddress; equals the PC register
- iInstruction  in  INSTR_WIDTH  ROM output for oAddress, combinational, same cycle
- iStall  in  1  downstream not ready; hold everything
- iBranchTaken  in  1  execute resolved a taken BLE/JMP on the instruction in oInstruction
- iBranchTarget  in  ADDR_WIDTH  redirect address, valid when iBranchTaken=1
- oInstruction  out  INSTR_WIDTH  instruction register to decode
- oPC  out  ADDR_WIDTH  address from which oInstruction was fetched
- oValid  out  1  oInstruction is a real, on-path instruction

## Operation

- State: PC register, IR, PC-of-IR register, valid flag, 2-state FSM {FETCH, FLUSH}.
- Reset (any time, including mid-stall or mid-redirect): PC=RESET_PC, oInstruction={`NOP,24'd0}, oPC=0, oValid=0, FSM=FETCH. First valid instruction appears one edge after Reset deasserts.
- Per edge, priority high to low:
  1. iBranchTaken=1: PC<=iBranchTarget; IR<=NOP word; oValid<=0; FSM<=FLUSH. Overrides iStall (the branching instruction is consumed). The instruction currently on iInstruction is wrong-path and is discarded.
  2. iStall=1: PC, IR, oPC, oValid, FSM all hold.
  3. Otherwise: IR<=iInstruction; oPC<=PC; oValid<=1; PC<=PC+1; FSM<=FETCH.
- FLUSH lasts exactly one cycle: in FLUSH with no new branch/stall, the target instruction is captured (step 3) and FSM returns to FETCH.
- Branch while in FLUSH cannot be legal (oValid=0); iBranchTaken is ignored when oValid=0.
- PC arithmetic: unsigned ADDR_WIDTH, modulo 2^ADDR_WIDTH; 0xFFFF+1 wraps to 0x0000 with no flag.
- Target taken verbatim; only the low ADDR_WIDTH bits of any wider constant are used.
- Fetch unit does not decode opcodes; NOP delay literals, LED, STO etc. pass through unchanged.

## Timing

- oAddress is a register output: no combinational path from any input to oAddress.
- Fetch latency: instruction at address A appears on oInstruction one edge after PC=A.
- Sequential throughput: one instruction per cycle when iStall=0.
- Taken-branch penalty: exactly one bubble cycle (oValid=0) between the branch and the target instruction.
- iStall has no effect on oAddress within the same cycle beyond holding PC.
- Reset asserts outputs asynchronously, without waiting for Clock.

## Structure

- Opcode constants (`NOP, `JMP, `BLE, …), register IDs and instruction field ranges (opcode [27:24], dest/target [23:16], src1 [15:8], src0 [7:0], literal [15:0]) remain in the shared definitions include; FSM state encodings (FETCH=0, FLUSH=1) are added there.
- Single module; no sub-module. PC incrementer is inline.
- Top level wires oAddress→ROM.iAddress and ROM.oInstruction→iInstruction.

## Test plan

- Reset then 5 free-running cycles, ROM model returns word = address → oAddress 0,1,2,3,4,5; oInstruction 0..4 lagging by one edge; oValid 0 on first edge only, then 1.
- PC=0x0005, iStall high for 3 cycles → oAddress stays 0x0005, oInstruction/oPC/oValid unchanged; on release next edge captures address 5.
- With oPC=12 valid, iBranchTaken=1, iBranchTarget=7 → next edge oValid=0, oInstruction=NOP, oAddress=7; following edge oInstruction=ROM[7], oPC=7, oValid=1.
- iBranchTaken=1 and iStall=1 simultaneously, target 14 → redirect wins: oAddress=14, oValid=0.
- PC forced to 0xFFFF via branch target → fetch 0xFFFF, next oAddress=0x0000, oPC=0xFFFF with oValid=1.
- Reset asserted mid-stall at PC=0x0009 between clock edges → outputs immediately PC=0, oValid=0, oInstruction=NOP; normal fetch from 0 after release.
